// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one pipelined signed multiplier among
// NUM_REQ requesters, tagging each issued pair so its product returns to its owner.
module mult_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 cfg_enable,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]             req_a,
    input  logic [NUM_REQ*WIDTH-1:0]             req_b,
    output logic [WIDTH-1:0]                     mul_a,
    output logic [WIDTH-1:0]                     mul_b,
    input  logic [2*WIDTH-1:0]                   mul_p,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [2*WIDTH-1:0]                   rsp_data,
    output logic [$clog2(MUL_LATENCY+3)-1:0]     in_flight,
    output logic                                 idle
);

    localparam int IDW = $clog2(NUM_REQ);

    // Handshake: a requester transfers on a rising edge where req_valid[i] && req_ready[i];
    // it holds valid and operands until then. Responses carry no backpressure.

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic             grant_found;
    logic             xfer;
    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    logic             iss_vld;
    logic [IDW-1:0]   iss_id;
    logic [MUL_LATENCY-1:0] tag_vld;
    logic [IDW-1:0]   tag_id [MUL_LATENCY];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        logic [IDW:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (IDW+1)'(rr_ptr) + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx[IDW-1:0];
            end
        end
        if (!cfg_enable || !reset_n) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign xfer = grant_found;
    assign idle = (in_flight == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            iss_vld   <= 1'b0;
            iss_id    <= '0;
            tag_vld   <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
            in_flight <= '0;
        end else begin
            if (xfer) begin
                rr_ptr  <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                mul_a   <= a_arr[grant_id];
                mul_b   <= b_arr[grant_id];
                iss_vld <= 1'b1;
                iss_id  <= grant_id;
            end else begin
                // Zero operands keep the multiplier datapath from toggling when idle.
                mul_a   <= '0;
                mul_b   <= '0;
                iss_vld <= 1'b0;
            end

            tag_vld[0] <= iss_vld;
            tag_id[0]  <= iss_id;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end

            if (tag_vld[MUL_LATENCY-1]) begin
                rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_id[MUL_LATENCY-1];
                rsp_data  <= mul_p;
            end else begin
                rsp_valid <= '0;
            end

            // An op counts until its response strobe cycle has completed.
            if (xfer && !(|rsp_valid)) begin
                in_flight <= in_flight + 1'b1;
            end else if (!xfer && (|rsp_valid)) begin
                in_flight <= in_flight - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier, queue-based reference
// model of arbitration and result return, directed scenarios plus random traffic.
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int L  = 2;
    localparam int CW = $clog2(L+3);

    logic             clk;
    logic             reset_n;
    logic             cfg_enable;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_data;
    logic [CW-1:0]    in_flight;
    logic             idle;

    logic [W-1:0]     op_a [N];
    logic [W-1:0]     op_b [N];

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .in_flight(in_flight), .idle(idle)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    // Behavioural multiplier: L register stages, not reset.
    logic signed [2*W-1:0] p_pipe [L];
    always @(posedge clk) begin
        p_pipe[0] <= $signed(mul_a) * $signed(mul_b);
        for (int s = 1; s < L; s++) p_pipe[s] <= p_pipe[s-1];
    end
    assign mul_p = p_pipe[L-1];

    // Scoreboard
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return (2*W)'(sa * sb);
    endfunction

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        int             e;
    } op_t;

    op_t            exp_q[$];
    int             mptr;
    logic [W-1:0]   exp_ma;
    logic [W-1:0]   exp_mb;
    logic [2*W-1:0] mdata;
    logic [N-1:0]   exp_rv;
    logic [N-1:0]   exp_rdy;
    logic           pop;
    int             g;

    int             grant_log[$];
    int             rsp_cnt;
    logic [2*W-1:0] rsp_by_id [N];
    int             g_edge [N];
    int             r_edge [N];
    int             lat [N];

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            mptr   = 0;
            exp_ma = '0;
            exp_mb = '0;
            mdata  = '0;
            check_eq("rst_req_ready", 32'(req_ready), 32'd0);
            check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("rst_rsp_data",  32'(rsp_data),  32'd0);
            check_eq("rst_in_flight", 32'(in_flight), 32'd0);
            check_eq("rst_idle",      32'(idle),      32'd1);
            check_eq("rst_mul_ab",    32'({mul_a, mul_b}), 32'd0);
        end else begin
            check_eq("mul_a", 32'(mul_a), 32'(exp_ma));
            check_eq("mul_b", 32'(mul_b), 32'(exp_mb));

            exp_rv = '0;
            pop    = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].e + L + 1 == edge_n) begin
                exp_rv = N'(1) << exp_q[0].id;
                mdata  = exp_q[0].prod;
                pop    = 1'b1;
            end
            check_eq("in_flight", 32'(in_flight), 32'(exp_q.size()));
            check_eq("idle",      32'(idle),      32'(exp_q.size() == 0));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check_eq("rsp_data",  32'(rsp_data),  32'(mdata));
            if (pop) void'(exp_q.pop_front());

            g = -1;
            if (cfg_enable) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (g >= 0) begin
                exp_q.push_back('{g, ref_mul(op_a[g], op_b[g]), edge_n + 1});
                mptr   = (g + 1) % N;
                exp_ma = op_a[g];
                exp_mb = op_b[g];
            end else begin
                exp_ma = '0;
                exp_mb = '0;
            end

            // Logs of what the DUT actually did, for the directed scenario checks.
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grant_log.push_back(i);
                    g_edge[i] = edge_n + 1;
                end
                if (rsp_valid[i]) begin
                    rsp_by_id[i] = rsp_data;
                    r_edge[i]    = edge_n;
                    lat[i]       = edge_n - g_edge[i];
                    rsp_cnt++;
                end
            end
        end
    end

    // Driver tasks
    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7f;
            2:       return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic offer(int i, logic [W-1:0] a, logic [W-1:0] b);
        op_a[i]      = a;
        op_b[i]      = b;
        req_valid[i] = 1'b1;
    endtask

    // One clock: completed handshakes either drop valid or reload a new random pair.
    task automatic step(logic [N-1:0] refill);
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (refill[i]) offer(i, rnd_op(), rnd_op());
                else           req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(int budget);
        for (int c = 0; c < budget && !(req_valid == '0 && idle); c++) step('0);
        check_eq("drain_done", 32'({req_valid, idle}), 32'(1));
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        cfg_enable = 1'b1;
        req_valid  = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
            rsp_by_id[i] = 16'hdead;
            g_edge[i] = 0;
            r_edge[i] = 0;
            lat[i] = 0;
        end
        rsp_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single requester
        offer(0, 8'd4, 8'd5);
        drain(12);
        check_eq("single_data", 32'(rsp_by_id[0]), 32'd20);
        check_eq("single_lat",  32'(lat[0]),       32'd3);
        check_eq("single_cnt",  32'(rsp_cnt),      32'd1);

        // All four valid from rr_ptr = 0
        reset_pulse();
        grant_log.delete();
        offer(0, 8'd10, -8'sd2);
        offer(1, -8'sd5, 8'd5);
        offer(2, -8'sd10, -8'sd10);
        offer(3, 8'd127, 8'd127);
        drain(16);
        check_eq("all4_ngrant", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check_eq("all4_order", 32'(grant_log[k]), 32'(k));
        check_eq("all4_r0", 32'(rsp_by_id[0]), 32'(16'hffec));
        check_eq("all4_r1", 32'(rsp_by_id[1]), 32'(16'hffe7));
        check_eq("all4_r2", 32'(rsp_by_id[2]), 32'd100);
        check_eq("all4_r3", 32'(rsp_by_id[3]), 32'd16129);
        for (int k = 1; k < 4; k++)
            check_eq("all4_back2back", 32'(r_edge[k] - r_edge[0]), 32'(k));

        // Fairness between req 0 and req 2
        grant_log.delete();
        offer(0, rnd_op(), rnd_op());
        offer(2, rnd_op(), rnd_op());
        repeat (8) step(4'b0101);
        drain(16);
        check_eq("fair_ngrant", 32'(grant_log.size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check_eq("fair_order", 32'(grant_log[k]), 32'((k % 2) * 2));

        // Sign boundaries
        for (int i = 0; i < N; i++) rsp_by_id[i] = 16'hdead;
        offer(1, 8'h80, 8'h01);
        offer(2, 8'h80, 8'h80);
        offer(3, 8'h00, 8'h80);
        drain(16);
        check_eq("sign_m128x1",    32'(rsp_by_id[1]), 32'(16'hff80));
        check_eq("sign_m128xm128", 32'(rsp_by_id[2]), 32'(16'h4000));
        check_eq("sign_0xm128",    32'(rsp_by_id[3]), 32'(16'h0000));

        // Drain with cfg_enable dropped
        rsp_cnt = 0;
        for (int i = 0; i < N; i++) offer(i, rnd_op(), rnd_op());
        repeat (3) step('0);
        cfg_enable = 1'b0;
        #1;
        check_eq("drain_ready",  32'(req_ready), 32'd0);
        check_eq("drain_inflt",  32'(in_flight), 32'd3);
        for (int c = 0; c < 10 && !idle; c++) step('0);
        check_eq("drain_rsp",    32'(rsp_cnt), 32'd3);
        check_eq("drain_idle",   32'(idle), 32'd1);
        check_eq("drain_left",   32'($countones(req_valid)), 32'd1);
        cfg_enable = 1'b1;
        drain(16);

        // Reset with two operations in flight
        offer(0, rnd_op(), rnd_op());
        offer(1, rnd_op(), rnd_op());
        step('0);
        step('0);
        reset_n = 1'b0;
        #1;
        check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("arst_in_flight", 32'(in_flight), 32'd0);
        check_eq("arst_idle",      32'(idle),      32'd1);
        check_eq("arst_mul_a",     32'(mul_a),     32'd0);
        check_eq("arst_rsp_data",  32'(rsp_data),  32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rsp_cnt = 0;
        repeat (6) step('0);
        check_eq("arst_no_stale", 32'(rsp_cnt), 32'd0);
        rsp_by_id[0] = 16'hdead;
        offer(0, 8'd3, 8'd3);
        drain(12);
        check_eq("arst_next_data", 32'(rsp_by_id[0]), 32'd9);
        check_eq("arst_next_lat",  32'(lat[0]),       32'd3);
        check_eq("arst_next_cnt",  32'(rsp_cnt),      32'd1);

        // Random traffic with cfg_enable toggling
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 99) < 60) offer(i, rnd_op(), rnd_op());
            if ($urandom_range(0, 99) < 5) cfg_enable = ~cfg_enable;
            step('0);
        end
        cfg_enable = 1'b1;
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
